bad_point_table_writer: RTL

- Write side of the bad-pixel LUT used by the manual bad-pixel checker.
- Receives detected bad-pixel coordinates during a frame and writes them in raster order into a ping-pong bad-point BRAM, using the checker's LUT write format {x[31:16], y[15:0]}.
- At frame end, commits the count and bank so the checker reads a stable, sorted table while the next frame records into the other bank.

---
 rtl/dpc_pkg.sv | 27 ++
 rtl/bad_point_table_writer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dpc_pkg.sv
// Shared definitions for the bad-pixel correction path: recorder FSM states
// and the LUT word layout that the checker also unpacks.
package dpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_COMMIT = 2'd2
    } wr_state_t;

    localparam int LUT_WORD_W  = 32;
    localparam int LUT_FIELD_W = 16;
    localparam int LUT_X_LSB   = 16;
    localparam int LUT_Y_LSB   = 0;

    function automatic logic [LUT_WORD_W-1:0] pack_xy(
        input logic [LUT_FIELD_W-1:0] x,
        input logic [LUT_FIELD_W-1:0] y
    );
        logic [LUT_WORD_W-1:0] w;
        w = '0;
        w[LUT_X_LSB +: LUT_FIELD_W] = x;
        w[LUT_Y_LSB +: LUT_FIELD_W] = y;
        return w;
    endfunction

endpackage

// File: rtl/bad_point_table_writer.sv
// Records raster-ordered bad-pixel coordinates into one bank of a ping-pong
// LUT and commits count/bank at frame end for the checker to read.
module bad_point_table_writer
    import dpc_pkg::*;
#(
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 10,
    parameter int BAD_POINT_NUM = 128,
    parameter int BAD_POINT_BIT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     frame_done,
    input  logic                     record_en,
    input  logic                     detect_valid,
    input  logic [WIDTH_BITS-1:0]    detect_x,
    input  logic [HEIGHT_BITS-1:0]   detect_y,
    output logic                     wen_lut,
    output logic [BAD_POINT_BIT:0]   waddr_lut,
    output logic [LUT_WORD_W-1:0]    wdata_lut,
    output logic [BAD_POINT_BIT:0]   bad_point_num,
    output logic                     rd_bank,
    output logic                     commit_pulse,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int KEY_W = HEIGHT_BITS + WIDTH_BITS;
    localparam logic [BAD_POINT_BIT:0] CNT_FULL = (BAD_POINT_BIT+1)'(BAD_POINT_NUM);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    wr_state_t              state, state_nx;
    logic                   fs_d;
    logic                   start_pend, pend_en;
    logic [BAD_POINT_BIT:0] count;
    logic [KEY_W-1:0]       last_key;
    logic                   last_valid;
    logic                   idle_bank;

    logic                   fs_edge;
    logic [KEY_W-1:0]       key;
    logic                   start_go, start_en;
    logic                   clear, wr_acc, drop_ord, ovf_hit, pend_set, pend_clr, commit;

    assign fs_edge  = frame_start & ~fs_d;
    assign key      = {detect_y, detect_x};
    assign start_go = fs_edge | start_pend;
    assign start_en = fs_edge ? record_en : pend_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        wr_acc   = 1'b0;
        drop_ord = 1'b0;
        ovf_hit  = 1'b0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_go) begin
                    pend_clr = 1'b1;
                    if (start_en) begin
                        state_nx = ST_RECORD;
                        clear    = 1'b1;
                    end
                end
            end
            ST_RECORD: begin
                // A new frame_start without frame_done aborts; frame_done wins if both arrive.
                if (fs_edge && !frame_done) begin
                    clear = 1'b1;
                    if (!record_en) state_nx = ST_IDLE;
                end else begin
                    if (detect_valid) begin
                        if (last_valid && (key <= last_key)) drop_ord = 1'b1;
                        else if (count == CNT_FULL)          ovf_hit  = 1'b1;
                        else                                 wr_acc   = 1'b1;
                    end
                    if (frame_done) state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit   = 1'b1;
                state_nx = ST_IDLE;
                if (fs_edge) pend_set = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Recording bank is the complement of idle_bank, so the first frame lands in bank 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_d          <= 1'b1;
            start_pend    <= 1'b0;
            pend_en       <= 1'b0;
            count         <= '0;
            last_key      <= '0;
            last_valid    <= 1'b0;
            idle_bank     <= 1'b1;
            wen_lut       <= 1'b0;
            waddr_lut     <= '0;
            wdata_lut     <= '0;
            bad_point_num <= '0;
            rd_bank       <= 1'b0;
            commit_pulse  <= 1'b0;
            overflow      <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            fs_d         <= frame_start;
            wen_lut      <= wr_acc;
            commit_pulse <= commit;
            if (pend_set) begin
                start_pend <= 1'b1;
                pend_en    <= record_en;
            end else if (pend_clr) begin
                start_pend <= 1'b0;
            end
            if (clear) begin
                count      <= '0;
                last_valid <= 1'b0;
                overflow   <= 1'b0;
                drop_cnt   <= '0;
            end
            if (wr_acc) begin
                waddr_lut  <= {~idle_bank, count[BAD_POINT_BIT-1:0]};
                wdata_lut  <= pack_xy(LUT_FIELD_W'(detect_x), LUT_FIELD_W'(detect_y));
                count      <= count + 1'b1;
                last_key   <= key;
                last_valid <= 1'b1;
            end
            if (drop_ord) drop_cnt <= sat_inc8(drop_cnt);
            if (ovf_hit)  overflow <= 1'b1;
            if (commit) begin
                bad_point_num <= count;
                rd_bank       <= ~idle_bank;
                idle_bank     <= ~idle_bank;
            end
        end
    end

endmodule
